accumulator_differencer: RTL and testbench
==========================================

// Module: accumulator_differencer
// PURPOSE
//  Inverse of the 16-bit feedback accumulator. Takes a stream of running sums and emits
//  the first difference out[n] = acc[n] - acc[n-1] (mod 2^WIDTH), which recovers the original
//  increments. Sits on the receive side of any link that carries accumulated values.
//  Uses valid/ready handshakes on both sides, with a 2-entry output buffer for backpressure.
// PARAMETERS
//  WIDTH       16  data width of running sums and differences
//  CNT_W       16  width of sample_count
//  FIRST_MODE  0   0: first sample after reset/clear is diffed against 0; 1: first sample only primes
// PORTS
//  clock         in   1       clock; all logic on rising edge
//  reset         in   1       reset, synchronous, active-high
//  clear         in   1       synchronous restart of difference history (state->PRIME, prev->0)
//  in_data       in   WIDTH   running-sum sample
//  in_valid      in   1       in_data valid
//  in_ready      out  1       block can accept; in_ready = (buf_count < 2)
//  out_data      out  WIDTH   difference at head of output buffer
//  out_valid     out  1       out_data valid (buf_count != 0)
//  out_ready     in   1       downstream accepts out_data
//  sample_count  out  CNT_W   number of output handshakes since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: prev=0, state=PRIME, buf_count=0, out_valid=0, out_data=0, in_ready=1, sample_count=0.
//    Reset overrides all other inputs and discards buffered data, including a reset mid-stream.
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//  - in_ready depends only on the registered buf_count. A pop in the same cycle does not
//    free a slot for a push in that cycle.
//  - diff = in_data - prev, truncated to WIDTH bits (two's-complement wrap; no overflow flag).
//  - FSM (transitions only on Accept, or on clear):
//      PRIME: Accept -> prev<=in_data; state<=RUN.
//             FIRST_MODE=0: push in_data (i.e. in_data - 0). FIRST_MODE=1: push nothing.
//      RUN:   Accept -> push diff; prev<=in_data.
//  - clear: forces state=PRIME and prev=0. If Accept happens in the same cycle, that sample
//    is handled as a PRIME sample: prev<=in_data, state<=RUN, and a push occurs if FIRST_MODE=0.
//    clear does not flush the output buffer or change sample_count.
//  - Output buffer: 2-entry FIFO, in order.
//      Latency: accepted at edge N -> visible on out_data/out_valid after edge N
//      (when the buffer was empty).
//      push&pop with buf_count=1: count stays 1, and the new entry becomes head after the pop.
//      Pop with count 0 cannot occur. Push with count 2 cannot occur (in_ready=0).
//  - out_data holds its value while out_valid=1 and out_ready=0. out_data=0 when out_valid=0.
//  - sample_count += 1 on each Pop; it wraps from 2^CNT_W-1 to 0.
//  - Full throughput: with out_ready held at 1, one sample per cycle is sustained.
// TESTING
//  1. FIRST_MODE=0, out_ready=1: in 0,5,12,12,65535 -> out 0,5,7,0,65523; sample_count=5.
//  2. Wrap: prev=16'hFFF0, in 16'h0010 -> out 16'h0020. Then in 16'h0000 -> out 16'hFFF0.
//  3. Backpressure: out_ready=0, in 10,30,60 back-to-back -> in_ready=0 after 2 accepts,
//     60 held. out_ready=1 -> out 10,20,30 in order, and in_ready returns to 1.
//  4. FIRST_MODE=1: after reset, in 100,130,125 -> out 30,65531 only. The first sample
//     produces no output.
//  5. clear mid-stream (FIRST_MODE=0): prev=500, clear with in 40 accepted -> out 40.
//     Next in 45 -> out 5.
//  6. Reset with 2 entries buffered, sample_count=7 -> after the edge: out_valid=0,
//     in_ready=1, sample_count=0, state=PRIME.

Source files
------------

// File: rtl/accumulator_differencer.sv
// ---------------------------------------------------------------------------
// accumulator_differencer
//
// Receive-side inverse of a feedback accumulator. Each accepted running-sum
// sample is differenced against the previously accepted sample
// (out = acc[n] - acc[n-1], wrapping modulo 2^WIDTH). This recovers the
// original increments. Results pass through a 2-entry in-order output FIFO.
// The FIFO lets the block absorb downstream backpressure without losing
// throughput.
//
// Parameters
//   WIDTH        data width of running sums and differences
//   CNT_W        width of sample_count
//   FIRST_MODE   0: first sample after reset/clear is differenced against 0
//                1: first sample after reset/clear only primes the history
//
// Ports
//   clock         in   1      rising-edge clock
//   reset         in   1      synchronous, active-high reset
//   clear         in   1      synchronous restart of difference history
//   in_data       in   WIDTH  running-sum sample
//   in_valid      in   1      in_data valid
//   in_ready      out  1      block can accept (fewer than 2 entries buffered)
//   out_data      out  WIDTH  difference at head of output buffer (0 if empty)
//   out_valid     out  1      out_data valid
//   out_ready     in   1      downstream accepts out_data
//   sample_count  out  CNT_W  output handshakes since reset, wrapping
// ---------------------------------------------------------------------------
module accumulator_differencer #(
   parameter int WIDTH      = 16,
   parameter int CNT_W      = 16,
   parameter bit FIRST_MODE = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] sample_count
);

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] w_prev_next;

   logic             w_accept;
   logic             w_pop;
   logic             w_push;
   logic [WIDTH-1:0] w_push_data;
   state_t           w_eff_state;

   // Output FIFO storage and bookkeeping
   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic [CNT_W-1:0] r_sample_count;

   // in_ready looks only at the registered count. A pop in the same cycle
   // therefore never frees a slot for a push in that cycle.
   assign in_ready     = (r_count != 2'd2);
   assign out_valid    = (r_count != 2'd0);
   assign out_data     = out_valid ? r_mem[r_rd_ptr] : '0;
   assign sample_count = r_sample_count;

   assign w_accept = in_valid & in_ready;
   assign w_pop    = out_valid & out_ready;

   // A clear in the same cycle as an accept makes that sample a PRIME sample.
   assign w_eff_state = clear ? ST_PRIME : r_state;

   // Next-state and push decision
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      w_state_next = r_state;
      w_prev_next  = r_prev;
      w_push       = 1'b0;
      w_push_data  = '0;

      if (clear) begin
         w_state_next = ST_PRIME;
         w_prev_next  = '0;
      end

      if (w_accept) begin
         w_prev_next  = in_data;
         w_state_next = ST_RUN;
         case (w_eff_state)
            ST_PRIME: begin
               // The implicit previous value is 0, so the difference is in_data itself.
               if (!FIRST_MODE) begin
                  w_push      = 1'b1;
                  w_push_data = in_data;
               end
            end
            ST_RUN: begin
               w_push      = 1'b1;
               w_push_data = in_data - r_prev;
            end
            default: ;
         endcase
      end
   end

   // State register and difference history
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      if (reset) begin
         r_state <= ST_PRIME;
         r_prev  <= '0;
      end else begin
         r_state <= w_state_next;
         r_prev  <= w_prev_next;
      end
   end

   // FIFO control and the output handshake counter
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr       <= 1'b0;
         r_rd_ptr       <= 1'b0;
         r_count        <= 2'd0;
         r_sample_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         if (w_pop) r_sample_count <= r_sample_count + CNT_W'(1);
      end
   end

   // NOTE: the data storage has no reset. Emptiness is tracked by r_count, and out_data is forced to 0 while the buffer is empty.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_data;
   end

endmodule

// File: tb/tb_accumulator_differencer.sv
// ---------------------------------------------------------------------------
// tb_accumulator_differencer
//
// Directed bench for accumulator_differencer. Two instances share all inputs:
// dut0 runs with FIRST_MODE=0 and dut1 with FIRST_MODE=1. Output handshakes
// of each instance are logged into a queue on the falling edge. Each test
// task compares these logs and the live outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_accumulator_differencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        o0_in_ready, o0_out_valid, o1_in_ready, o1_out_valid;
   logic [15:0] o0_out_data, o1_out_data, o0_sample_count, o1_sample_count;

   logic [15:0] q0[$];
   logic [15:0] q1[$];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   accumulator_differencer #(.WIDTH(16), .CNT_W(16), .FIRST_MODE(1'b0)) dut0 (
      .clock(clock), .reset(reset), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(o0_in_ready),
      .out_data(o0_out_data), .out_valid(o0_out_valid), .out_ready(out_ready),
      .sample_count(o0_sample_count)
   );

   accumulator_differencer #(.WIDTH(16), .CNT_W(16), .FIRST_MODE(1'b1)) dut1 (
      .clock(clock), .reset(reset), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(o1_in_ready),
      .out_data(o1_out_data), .out_valid(o1_out_valid), .out_ready(out_ready),
      .sample_count(o1_sample_count)
   );

   // Inputs only change just after a rising edge. A handshake seen here
   // therefore completes on the next rising edge.
   always @(negedge clock) begin
      if (!reset && o0_out_valid && out_ready) q0.push_back(o0_out_data);
      if (!reset && o1_out_valid && out_ready) q1.push_back(o1_out_data);
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      idle(2);
      reset = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   // Present one sample and hold it until dut0 accepts it (bounded wait).
   task automatic send(input logic [15:0] d);
      int n = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!o0_in_ready && n < 50) begin
         idle(1);
         n++;
      end
      if (!o0_in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout data=%0d in_ready stayed %b", d, o0_in_ready);
      end
      idle(1);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o0_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", o0_out_valid); end
      checks++; if (o0_out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", o0_out_data); end
      checks++; if (o0_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", o0_in_ready); end
      checks++; if (o0_sample_count !== 16'd0) begin errors++; $display("FAIL reset_sample_count got %0d want 0", o0_sample_count); end
   endtask

   task automatic test_stream();
      logic [15:0] exp [5];
      exp = '{16'd0, 16'd5, 16'd7, 16'd0, 16'd65523};
      do_reset();
      out_ready = 1'b1;
      send(16'd0); send(16'd5); send(16'd12); send(16'd12); send(16'd65535);
      idle(4);
      checks++; if (q0.size() !== 5) begin errors++; $display("FAIL stream_count got %0d want 5", q0.size()); end
      for (int i = 0; i < 5 && i < q0.size(); i++) begin
         checks++;
         if (q0[i] !== exp[i]) begin errors++; $display("FAIL stream_out%0d got %0d want %0d", i, q0[i], exp[i]); end
      end
      checks++; if (o0_sample_count !== 16'd5) begin errors++; $display("FAIL stream_sample_count got %0d want 5", o0_sample_count); end
   endtask

   task automatic test_wrap();
      q0.delete();
      send(16'hFFF0); send(16'h0010); send(16'h0000);
      idle(4);
      checks++; if (q0.size() !== 3) begin errors++; $display("FAIL wrap_count got %0d want 3", q0.size()); end
      checks++; if (q0[0] !== 16'hFFF1) begin errors++; $display("FAIL wrap_prime got %h want fff1", q0[0]); end
      checks++; if (q0[1] !== 16'h0020) begin errors++; $display("FAIL wrap_up got %h want 0020", q0[1]); end
      checks++; if (q0[2] !== 16'hFFF0) begin errors++; $display("FAIL wrap_down got %h want fff0", q0[2]); end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_data = 16'd10; in_valid = 1'b1;
      idle(1);
      checks++; if (o0_in_ready !== 1'b1 || o0_out_data !== 16'd10 || o0_out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_first ready=%b valid=%b data=%0d want 1 1 10", o0_in_ready, o0_out_valid, o0_out_data); end
      in_data = 16'd30;
      idle(1);
      checks++; if (o0_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", o0_in_ready); end
      in_data = 16'd60;
      idle(2);
      checks++; if (o0_in_ready !== 1'b0 || o0_out_data !== 16'd10) begin
         errors++; $display("FAIL bp_hold ready=%b data=%0d want 0 10", o0_in_ready, o0_out_data); end
      out_ready = 1'b1;
      send(16'd60);
      idle(4);
      checks++; if (q0.size() !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", q0.size()); end
      checks++; if (q0[0] !== 16'd10 || q0[1] !== 16'd20 || q0[2] !== 16'd30) begin
         errors++; $display("FAIL bp_order got %0d %0d %0d want 10 20 30", q0[0], q0[1], q0[2]); end
      checks++; if (o0_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", o0_in_ready); end
   endtask

   task automatic test_first_mode1();
      do_reset();
      out_ready = 1'b1;
      send(16'd100); send(16'd130); send(16'd125);
      idle(4);
      checks++; if (q1.size() !== 2) begin errors++; $display("FAIL fm1_count got %0d want 2", q1.size()); end
      checks++; if (q1[0] !== 16'd30) begin errors++; $display("FAIL fm1_out0 got %0d want 30", q1[0]); end
      checks++; if (q1[1] !== 16'd65531) begin errors++; $display("FAIL fm1_out1 got %0d want 65531", q1[1]); end
      checks++; if (o1_sample_count !== 16'd2) begin errors++; $display("FAIL fm1_sample_count got %0d want 2", o1_sample_count); end
   endtask

   task automatic test_clear();
      do_reset();
      out_ready = 1'b1;
      send(16'd500);
      clear = 1'b1;
      send(16'd40);
      clear = 1'b0;
      send(16'd45);
      idle(4);
      checks++; if (q0.size() !== 3) begin errors++; $display("FAIL clr_count got %0d want 3", q0.size()); end
      checks++; if (q0[1] !== 16'd40) begin errors++; $display("FAIL clr_prime got %0d want 40", q0[1]); end
      checks++; if (q0[2] !== 16'd5) begin errors++; $display("FAIL clr_next got %0d want 5", q0[2]); end
      checks++; if (o0_sample_count !== 16'd3) begin errors++; $display("FAIL clr_sample_count got %0d want 3", o0_sample_count); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) send(16'(i * 3));
      idle(3);
      out_ready = 1'b0;
      send(16'd100); send(16'd200);
      checks++; if (o0_sample_count !== 16'd7 || o0_in_ready !== 1'b0) begin
         errors++; $display("FAIL mid_setup count=%0d ready=%b want 7 0", o0_sample_count, o0_in_ready); end
      reset = 1'b1;
      idle(1);
      checks++; if (o0_out_valid !== 1'b0 || o0_out_data !== 16'd0) begin
         errors++; $display("FAIL mid_flush valid=%b data=%0d want 0 0", o0_out_valid, o0_out_data); end
      checks++; if (o0_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", o0_in_ready); end
      checks++; if (o0_sample_count !== 16'd0) begin errors++; $display("FAIL mid_sample_count got %0d want 0", o0_sample_count); end
      reset = 1'b0;
      q0.delete(); q1.delete();
      out_ready = 1'b1;
      send(16'd9); send(16'd12);
      idle(4);
      // PRIME after reset: dut0 diffs 9 against 0; dut1 emits only 12-9.
      checks++; if (q0.size() !== 2 || q0[0] !== 16'd9) begin
         errors++; $display("FAIL mid_prime0 size=%0d first=%0d want 2 9", q0.size(), q0[0]); end
      checks++; if (q1.size() !== 1 || q1[0] !== 16'd3) begin
         errors++; $display("FAIL mid_prime1 size=%0d first=%0d want 1 3", q1.size(), q1[0]); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wrap();
      test_backpressure();
      test_first_mode1();
      test_clear();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
